gshare_pattern_table: RTL and testbench
=======================================

# gshare_pattern_table

Pattern history table for the branch predictor: an array of 2-bit saturating counters indexed by branch PC bits XORed with the global history, sitting directly downstream of the global history register. It answers fetch-stage lookups one cycle after the request and trains counters from execute-stage resolutions. On each resolution it also drives the history register's shift/taken inputs and flags mispredictions.

## Interface
Parameters:
- GHR_W, 3, width of the global history input; must satisfy GHR_W <= IDX_W.
- IDX_W, 4, table index width; the table holds 2^IDX_W counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ghr  input  GHR_W  current global history value.
- lk_valid  input  1  lookup request.
- lk_pc  input  32  branch PC for the lookup.
- pred_valid  output  1  prediction valid, one cycle after lk_valid.
- pred_taken  output  1  predicted direction (counter MSB).
- pred_idx  output  IDX_W  index used; carried down the pipe and returned as upd_idx.
- upd_valid  input  1  branch resolved this cycle.
- upd_idx  input  IDX_W  index returned from the matching lookup.
- upd_taken  input  1  actual outcome.
- upd_pred  input  1  prediction that was used for this branch.
- ghr_shift  output  1  drives the history register's shift input; equals upd_valid (combinational).
- ghr_taken  output  1  drives the history register's taken input; equals upd_taken (combinational).
- upd_mispredict  output  1  registered; high one cycle after upd_valid when upd_pred != upd_taken.

## Operation
- Index computation: idx = lk_pc[IDX_W+1:2] XOR {zeros, ghr}, with ghr zero-extended to IDX_W bits.
- Counter encoding:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Prediction is counter[1].
- Update, when upd_valid is high:
  - upd_taken=1: counter increments, saturating at 11.
  - upd_taken=0: counter decrements, saturating at 00.
  - Only the entry at upd_idx changes.
- Lookup, when lk_valid is high:
  - pred_idx is registered as idx.
  - pred_taken is registered as the MSB of the counter at idx.
  - pred_valid is registered as 1.
  - When lk_valid is low, pred_valid is 0 and pred_taken/pred_idx hold their previous values.
- Same-cycle lookup and update to the same index:
  - The lookup is forwarded the post-update counter value.
  - Different indices are independent.
- upd_mispredict is registered as upd_valid & (upd_pred ^ upd_taken), and is 0 otherwise.
- ghr_shift and ghr_taken are pure pass-throughs, so the history register shifts at the same edge at which the counter trains.
- Reset:
  - All counters go to 01.
  - pred_valid, pred_taken, pred_idx and upd_mispredict go to 0.
  - Reset takes priority over a concurrent update or lookup; that operation is discarded.
  - ghr_shift/ghr_taken still follow their inputs during reset.

## Timing
- Lookup latency: 1 cycle. Request at edge N produces pred_* valid after edge N+1, for one cycle per request.
- Back-to-back lookups are accepted every cycle; there is no stall or backpressure.
- Update is written at the edge ending the upd_valid cycle. It is visible to lookups in the same cycle (via forwarding) and in all later cycles.
- upd_mispredict lags upd_valid by exactly 1 cycle.
- The ghr value is sampled in the lookup cycle. A shift at that same edge does not affect that lookup's index.
- Reset completes in 1 cycle. The first lookup may be issued in the cycle after reset deasserts.

## Test plan
- Reset/default:
  - Stimulus: reset; then lookup lk_pc=0x10, ghr=000.
  - Required: next cycle pred_valid=1, pred_idx=4, pred_taken=0.
- XOR indexing:
  - Stimulus: lk_pc=0x10, ghr=101.
  - Required: pred_idx=1.
  - Stimulus: lk_pc=0x3C, ghr=111.
  - Required: pred_idx=0xF^0x7=8.
- Training and saturation on idx 4:
  - Two taken updates, then lookup: pred_taken=1.
  - Three more taken updates, then one not-taken update: pred_taken=1 (11 saturated, now 10).
  - Five more not-taken updates (saturating at 00), then one taken update: pred_taken=0 (counter 01).
- Forwarding:
  - Counter 4 at 01; same cycle, upd_valid with upd_idx=4, upd_taken=1, plus a lookup hitting idx 4.
  - Required: pred_taken=1. A parallel update to idx 5 leaves an idx 4 lookup unchanged.
- Mispredict and history drive:
  - Stimulus: upd_valid, upd_pred=0, upd_taken=1.
  - Required: ghr_shift=1 and ghr_taken=1 the same cycle; upd_mispredict=1 the next cycle.
  - Stimulus: upd_pred=1, upd_taken=1.
  - Required: upd_mispredict=0.
- Reset mid-operation:
  - Train idx 4 to 11, then assert reset in the same cycle as lk_valid and upd_valid.
  - Required: next cycle pred_valid=0 and upd_mispredict=0; a subsequent lookup at idx 4 gives pred_taken=0 (counter 01).

Source files
------------

// File: rtl/gshare_pattern_table.sv
// gshare pattern history table: 2-bit saturating counters indexed by
// PC[IDX_W+1:2] XOR the global history. Lookups answer one cycle after the
// request; resolutions train one counter and drive the history register.
module gshare_pattern_table #(
  parameter int GHR_W = 3,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [GHR_W-1:0] ghr,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             ghr_shift,
  output logic             ghr_taken,
  output logic             upd_mispredict
);

  localparam int DEPTH = 32'sd1 << IDX_W;

  // Counter states
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  logic [1:0]       cnt_r [DEPTH];
  logic [IDX_W-1:0] ghr_ext_s;
  logic [IDX_W-1:0] lk_idx_s;
  logic [1:0]       upd_cnt_s;
  logic [1:0]       lk_cnt_s;
  logic             unused_s;

  // Next value of a 2-bit saturating counter after one resolved branch.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    case (cnt)
      CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
      default: nxt = CNT_WNT;
    endcase
    return nxt;
  endfunction

  // PC bits outside the index field do not take part in the hash.
  assign unused_s = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};

  // Hash the lookup PC with the zero-extended global history.
  always_comb begin
    ghr_ext_s              = '0;
    ghr_ext_s[GHR_W-1:0]   = ghr;
    lk_idx_s               = lk_pc[IDX_W+1:2] ^ ghr_ext_s;
  end

  // Trained counter value and lookup read with same-cycle forwarding.
  always_comb begin
    upd_cnt_s = sat_next(cnt_r[upd_idx], upd_taken);
    if (upd_valid && (upd_idx == lk_idx_s)) begin
      lk_cnt_s = upd_cnt_s;
    end else begin
      lk_cnt_s = cnt_r[lk_idx_s];
    end
  end

  // Counter array: reset to weak not-taken, train the resolved entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i[IDX_W-1:0]] <= CNT_WNT;
      end
    end else if (upd_valid) begin
      cnt_r[upd_idx] <= upd_cnt_s;
    end
  end

  // Prediction outputs: valid pulses per lookup, direction/index hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= lk_valid;
      if (lk_valid) begin
        pred_taken <= lk_cnt_s[1];
        pred_idx   <= lk_idx_s;
      end
    end
  end

  // Mispredict flag lags the resolution by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_mispredict <= 1'b0;
    end else begin
      upd_mispredict <= upd_valid & (upd_pred ^ upd_taken);
    end
  end

  // History register shifts on the same edge that trains the counter.
  assign ghr_shift = upd_valid;
  assign ghr_taken = upd_taken;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Self-checking bench for gshare_pattern_table: directed scenarios followed by
// randomized traffic, all checked against an integer-counter reference model.
module tb_gshare_pattern_table;

  logic        clk = 1'b0;
  logic        reset, lk_valid, pred_valid, pred_taken;
  logic        upd_valid, upd_taken, upd_pred, ghr_shift, ghr_taken, upd_mispredict;
  logic [2:0]  ghr;
  logic [31:0] lk_pc;
  logic [3:0]  pred_idx, upd_idx;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state: plain integer counters 0..3
  int         model [16];
  logic       exp_pv, exp_pt, exp_mis;
  logic [3:0] exp_pi;

  gshare_pattern_table #(.GHR_W(3), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .ghr(ghr), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .ghr_shift(ghr_shift), .ghr_taken(ghr_taken),
    .upd_mispredict(upd_mispredict)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle, predict its outcome with the model, check after the edge.
  task automatic do_cycle(input logic rst, input logic lkv, input logic [31:0] pc,
                          input logic [2:0] g, input logic uv, input logic [3:0] ui,
                          input logic ut, input logic up);
    int idx;
    reset = rst; lk_valid = lkv; lk_pc = pc; ghr = g;
    upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
    #2;
    check("ghr_shift", {31'd0, ghr_shift}, {31'd0, uv});
    check("ghr_taken", {31'd0, ghr_taken}, {31'd0, ut});
    idx = int'(pc[5:2]) ^ int'(g);
    if (rst) begin
      foreach (model[i]) model[i] = 1;
      exp_pv = 1'b0; exp_pt = 1'b0; exp_pi = 4'd0; exp_mis = 1'b0;
    end else begin
      if (uv) begin
        if (ut) model[ui] = (model[ui] < 3) ? model[ui] + 1 : 3;
        else    model[ui] = (model[ui] > 0) ? model[ui] - 1 : 0;
      end
      exp_mis = uv & (up ^ ut);
      if (lkv) begin
        exp_pv = 1'b1;
        exp_pi = idx[3:0];
        exp_pt = (model[idx] >= 2);
      end else begin
        exp_pv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("pred_valid", {31'd0, pred_valid}, {31'd0, exp_pv});
    check("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pt});
    check("pred_idx", {28'd0, pred_idx}, {28'd0, exp_pi});
    check("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, exp_mis});
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [2:0] g);
    do_cycle(1'b0, 1'b1, pc, g, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [3:0] ui, input logic ut, input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, ui, ut, ut);
  endtask

  initial begin
    logic       rst_r, lkv_r, uv_r, ut_r, up_r;
    logic [31:0] pc_r;
    logic [2:0] g_r;
    logic [3:0] ui_r, li_r;

    exp_pt = 1'b0; exp_pi = 4'd0;
    do_cycle(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    check("rst_mispredict", {31'd0, upd_mispredict}, 32'd0);

    lookup(32'h10, 3'b000);
    check("tp_reset_pv", {31'd0, pred_valid}, 32'd1);
    check("tp_reset_idx", {28'd0, pred_idx}, 32'd4);
    check("tp_reset_pt", {31'd0, pred_taken}, 32'd0);

    lookup(32'h10, 3'b101);
    check("tp_xor_a", {28'd0, pred_idx}, 32'd1);
    lookup(32'h3C, 3'b111);
    check("tp_xor_b", {28'd0, pred_idx}, 32'd8);

    train(4'd4, 1'b1, 2);
    lookup(32'h10, 3'b000);
    check("tp_train_t2", {31'd0, pred_taken}, 32'd1);
    train(4'd4, 1'b1, 3);
    train(4'd4, 1'b0, 1);
    lookup(32'h10, 3'b000);
    check("tp_sat_hi", {31'd0, pred_taken}, 32'd1);
    train(4'd4, 1'b0, 5);
    train(4'd4, 1'b1, 1);
    lookup(32'h10, 3'b000);
    check("tp_sat_lo", {31'd0, pred_taken}, 32'd0);

    // counter 4 now weak not-taken: unrelated update must not leak in
    do_cycle(1'b0, 1'b1, 32'h10, 3'd0, 1'b1, 4'd5, 1'b1, 1'b1);
    check("tp_fwd_other", {31'd0, pred_taken}, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h10, 3'd0, 1'b1, 4'd4, 1'b1, 1'b0);
    check("tp_fwd_same", {31'd0, pred_taken}, 32'd1);

    do_cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 4'd2, 1'b1, 1'b0);
    check("tp_mispred", {31'd0, upd_mispredict}, 32'd1);
    do_cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 4'd2, 1'b1, 1'b1);
    check("tp_no_mispred", {31'd0, upd_mispredict}, 32'd0);

    train(4'd4, 1'b1, 3);
    do_cycle(1'b1, 1'b1, 32'h10, 3'd0, 1'b1, 4'd4, 1'b1, 1'b0);
    check("tp_rst_mid_pv", {31'd0, pred_valid}, 32'd0);
    check("tp_rst_mid_mis", {31'd0, upd_mispredict}, 32'd0);
    lookup(32'h10, 3'b000);
    check("tp_rst_mid_pt", {31'd0, pred_taken}, 32'd0);

    // Randomized traffic, biased so updates often hit the looked-up entry
    for (int n = 0; n < 600; n++) begin
      rst_r = ($urandom_range(0, 59) == 0);
      lkv_r = 1'($urandom_range(0, 1));
      pc_r  = $urandom;
      g_r   = 3'($urandom_range(0, 7));
      li_r  = pc_r[5:2] ^ {1'b0, g_r};
      uv_r  = 1'($urandom_range(0, 1));
      ui_r  = ($urandom_range(0, 1) == 1) ? li_r : 4'($urandom_range(0, 15));
      ut_r  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (n >= 300) ut_r = ~ut_r;
      up_r  = 1'($urandom_range(0, 1));
      do_cycle(rst_r, lkv_r, pc_r, g_r, uv_r, ui_r, ut_r, up_r);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
